// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and mult/div occupancy controller.
//
// Detects load-use and mult/div hazards for the instruction in ID, turns
// them into PC / IF/ID / ID/EX control, and tracks the multi-cycle
// mult/div unit. A taken branch in EX takes priority over any stall.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   id_rs, id_rt              ID source register numbers
//   id_use_rs, id_use_rt      ID instruction reads rs / rt
//   id_md_op                  ID instruction touches HI/LO or mult/div
//   ex_memread, ex_wreg       EX instruction is a load / its destination
//   ex_md_start, ex_md_div    EX starts a mult/div (div=1 selects divide)
//   ex_taken                  EX branch/jump resolved taken
//   pc_we, ifid_we            PC and IF/ID write enables
//   ifid_flush, idex_flush    IF/ID flush to nop, ID/EX bubble insert
//   md_busy, md_done          unit occupied / one-cycle result-valid pulse
//   stall_cnt, flush_cnt      wrapping performance counters
module hazard_ctrl #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md_op,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  input  logic        ex_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  // Counter reload values: the unit stays busy for cnt+1 cycles.
  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYC - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_d;
  logic       load_use;
  logic       md_stall;
  logic       stall;

  assign md_busy = (state_q != IDLE);

  assign load_use = ex_memread && (ex_wreg != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_wreg)) ||
                     (id_use_rt && (id_rt == ex_wreg)));

  // A start in EX this cycle blocks an ID HI/LO access just like a busy unit.
  assign md_stall = id_md_op && (md_busy || ex_md_start);
  assign stall    = load_use || md_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_md_start) begin
          if (ex_md_div) begin
            state_d = DIV_BUSY;
            cnt_d   = DIV_LOAD;
          end else begin
            state_d = MUL_BUSY;
            cnt_d   = MUL_LOAD;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        // ex_md_start is deliberately ignored here: no restart or reload.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      md_done   <= 1'b0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_done <= done_d;
      if (ex_taken) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  // Zero-latency pipeline control; held at free-run while in reset so the
  // pipeline registers can reset themselves.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rstn) begin
      if (ex_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYC, default 5, execute cycles of a multiply; legal range 1..255.
REQ-002 Parameter DIV_CYC, default 10, execute cycles of a divide; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 id_md_op  input  1  ID instruction accesses HI/LO or the mult/div unit (mfhi, mflo, mthi, mtlo, mult, div).
REQ-008 ex_memread  input  1  EX instruction is a load.
REQ-009 ex_wreg  input  5  destination register of the EX instruction.
REQ-010 ex_md_start  input  1  EX instruction starts a mult/div this cycle.
REQ-011 ex_md_div  input  1  qualifies ex_md_start: 1 = divide, 0 = multiply.
REQ-012 ex_taken  input  1  branch/jump resolved taken in EX; PC redirect this cycle.
REQ-013 pc_we  output  1  PC register write enable.
REQ-014 ifid_we  output  1  IF/ID register write enable.
REQ-015 ifid_flush  output  1  load IF/ID with PC 0x3000 and instruction 0 (nop) at the next edge.
REQ-016 idex_flush  output  1  insert a bubble into ID/EX at the next edge.
REQ-017 md_busy  output  1  mult/div unit occupied.
REQ-018 md_done  output  1  one-cycle pulse: mult/div result valid in HI/LO.
REQ-019 stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-020 The block SHALL hold state IDLE, MUL_BUSY or DIV_BUSY, plus an 8-bit down-counter cnt.
REQ-021 In IDLE with ex_md_start=1, the block SHALL move to DIV_BUSY (cnt<=DIV_CYC-1) if ex_md_div=1, otherwise to MUL_BUSY (cnt<=MUL_CYC-1).
REQ-022 In MUL_BUSY or DIV_BUSY, the block SHALL decrement cnt each cycle while cnt!=0; with cnt==0 it SHALL return to IDLE and set md_done=1 for exactly the following cycle.
REQ-023 The block SHALL ignore ex_md_start while not in IDLE; no restart, no counter reload.
REQ-024 md_busy SHALL equal (state!=IDLE), combinationally, so it is high for exactly MUL_CYC or DIV_CYC cycles after the start edge.
REQ-025 The block SHALL compute load_use = ex_memread & (ex_wreg!=0) & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).
REQ-026 The block SHALL compute md_stall = id_md_op & (md_busy | ex_md_start).
REQ-027 The block SHALL compute stall = load_use | md_stall.
REQ-028 Priority 1: when ex_taken=1, the outputs SHALL be pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, regardless of stall.
REQ-029 Priority 2: when ex_taken=0 and stall=1, the outputs SHALL be pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1.
REQ-030 Otherwise the outputs SHALL be pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0.
REQ-031 pc_we, ifid_we, ifid_flush and idex_flush SHALL be combinational with zero latency; md_done, state, cnt and the counters SHALL be registered.
REQ-032 stall_cnt SHALL increment on each edge where ex_taken=0 and stall=1.
REQ-033 flush_cnt SHALL increment on each edge where ex_taken=1.
REQ-034 Both counters SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0).

Reset
REQ-035 On an edge with rstn=0, the block SHALL set state=IDLE, cnt=0, md_done=0, stall_cnt=0, flush_cnt=0.
REQ-036 While rstn=0, the outputs SHALL be pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0; the pipeline registers reset themselves.
REQ-037 Reset asserted mid-operation SHALL abort any busy state at that edge, with no md_done pulse.

Verification
REQ-038 ex_memread=1, ex_wreg=8, id_use_rt=1, id_rt=8, ex_taken=0 -> pc_we=0, ifid_we=0, idex_flush=1; stall_cnt +1.
REQ-039 Same as REQ-038 but ex_wreg=0 -> no stall; pc_we=1, idex_flush=0.
REQ-040 ex_md_start=1, ex_md_div=0 at edge T, defaults -> md_busy high for 5 cycles after T, md_done high in the 6th cycle only; id_md_op=1 during busy -> stall.
REQ-041 load_use=1 and ex_taken=1 in the same cycle -> pc_we=1, ifid_flush=1, idex_flush=1; flush_cnt +1, stall_cnt unchanged.
REQ-042 Divide started, rstn=0 for one edge at the 4th busy cycle -> state IDLE, md_busy=0, md_done never pulses, counters 0.
REQ-043 Force stall_cnt to 0xFFFFFFFF, apply one stall cycle -> stall_cnt=0.
